// File: rtl/hack_prog_loader.sv
// rtl/hack_prog_loader.sv - HACK CPU program loader and run controller
// Optional feature macro: HACK_LOADER_CHECKSUM_EN adds a running checksum of loaded words.
module hack_prog_loader #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 15,
    parameter int PC_W     = 16,
    parameter int RST_HOLD = 4,
    parameter int HALT_CYC = 8,
    parameter int MAX_CYC  = 1000,
    parameter int CYC_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    output logic              cpu_reset,
    input  logic [PC_W-1:0]   pc_in,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              timeout,
    output logic              overflow,
    output logic [ADDR_W:0]   words_loaded,
`ifdef HACK_LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [CYC_W-1:0]  cycles
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int STAB_W = $clog2(HALT_CYC + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [STAB_W-1:0] STAB_HALT = STAB_W'(HALT_CYC - 1);
    localparam logic [CYC_W-1:0]  CYC_LIMIT = CYC_W'(MAX_CYC);
    localparam logic [ADDR_W-1:0] ADDR_TOP  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STAB_W-1:0] stab_cnt;
    logic [STAB_W-1:0] stab_next;
    logic [PC_W-1:0]   pc_q;
    logic [CYC_W-1:0]  cycles_next;
    logic              accept;
    logic              pc_same;

    assign accept    = s_valid & s_ready;
    assign rom_we    = accept;
    assign rom_addr  = words_loaded[ADDR_W-1:0];
    assign rom_wdata = s_data;

    // pc_q holds a pre-run value on the first RUN cycle, so that cycle never counts as stable.
    assign pc_same     = (cycles != '0) && (pc_in == pc_q);
    assign stab_next   = pc_same ? stab_cnt + 1'b1 : '0;
    assign cycles_next = cycles + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cpu_reset    <= 1'b1;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            halted       <= 1'b0;
            timeout      <= 1'b0;
            overflow     <= 1'b0;
            words_loaded <= '0;
            cycles       <= '0;
            hold_cnt     <= '0;
            stab_cnt     <= '0;
            pc_q         <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            pc_q <= pc_in;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state        <= ST_LOAD;
                        cpu_reset    <= 1'b1;
                        s_ready      <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        halted       <= 1'b0;
                        timeout      <= 1'b0;
                        overflow     <= 1'b0;
                        words_loaded <= '0;
                        cycles       <= '0;
                        hold_cnt     <= '0;
                        stab_cnt     <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
                        checksum     <= '0;
`endif
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        words_loaded <= words_loaded + 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
                        checksum     <= checksum + s_data;
`endif
                        // The top address ends the load even without s_last: no wrap.
                        if (s_last || (rom_addr == ADDR_TOP)) begin
                            state    <= ST_HOLD;
                            s_ready  <= 1'b0;
                            overflow <= ~s_last;
                            hold_cnt <= '0;
                        end
                    end
                end

                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= ST_RUN;
                        cpu_reset <= 1'b0;
                        stab_cnt  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    cycles   <= cycles_next;
                    stab_cnt <= stab_next;
                    // Halt detection takes priority when both end conditions coincide.
                    if (stab_next == STAB_HALT) begin
                        halted    <= 1'b1;
                        state     <= ST_DONE;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (cycles_next == CYC_LIMIT) begin
                        timeout   <= 1'b1;
                        state     <= ST_DONE;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    cpu_reset <= 1'b1;
                    s_ready   <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_prog_loader.sv
// tb/tb_hack_prog_loader.sv - randomized bench for hack_prog_loader against a behavioural model
module tb_hack_prog_loader;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 2;
    localparam int PC_W     = 16;
    localparam int RST_HOLD = 4;
    localparam int HALT_CYC = 8;
    localparam int MAX_CYC  = 1000;
    localparam int CYC_W    = 32;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_wdata;
    logic              cpu_reset;
    logic [PC_W-1:0]   pc_in = '0;
    logic              busy;
    logic              done;
    logic              halted;
    logic              timeout;
    logic              overflow;
    logic [ADDR_W:0]   words_loaded;
    logic [CYC_W-1:0]  cycles;
`ifdef HACK_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    hack_prog_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .RST_HOLD(RST_HOLD),
        .HALT_CYC(HALT_CYC), .MAX_CYC(MAX_CYC), .CYC_W(CYC_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_last(s_last),
        .s_ready(s_ready),
        .rom_we(rom_we),
        .rom_addr(rom_addr),
        .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset),
        .pc_in(pc_in),
        .busy(busy),
        .done(done),
        .halted(halted),
        .timeout(timeout),
        .overflow(overflow),
        .words_loaded(words_loaded),
`ifdef HACK_LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .cycles(cycles)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the loaded image, the PC history of the current run and a few flags.
    typedef enum int {M_IDLE, M_LOAD, M_HOLD, M_RUN, M_DONE} mode_t;

    mode_t             m_mode = M_IDLE;
    logic [DATA_W-1:0] m_img[$];
    logic [PC_W-1:0]   m_run[$];
    bit                m_halt = 0;
    bit                m_tout = 0;
    bit                m_ovf = 0;
    logic [DATA_W-1:0] m_chk = '0;
    longint            m_now = 0;
    longint            m_tacc = 0;

    int                writes_seen = 0;
    logic [DATA_W-1:0] rom_log [DEPTH] = '{default: 16'hDEAD};

    function automatic bit tail_same();
        int n = m_run.size();
        for (int i = 1; i < HALT_CYC; i++)
            if (m_run[n-1-i] != m_run[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        m_img.delete();
        m_run.delete();
        m_halt = 0;
        m_tout = 0;
        m_ovf  = 0;
        m_chk  = '0;
    endtask

    task automatic model_step();
        case (m_mode)
            M_IDLE, M_DONE: begin
                if (start) begin
                    model_clear();
                    m_mode = M_LOAD;
                end
            end
            M_LOAD: begin
                if (s_valid) begin
                    m_img.push_back(s_data);
                    m_chk = m_chk + s_data;
                    if (s_last || m_img.size() == DEPTH) begin
                        m_ovf  = !s_last;
                        m_mode = M_HOLD;
                        m_tacc = m_now;
                    end
                end
            end
            M_HOLD: begin
                if (m_now - m_tacc == RST_HOLD) m_mode = M_RUN;
            end
            M_RUN: begin
                m_run.push_back(pc_in);
                if (m_run.size() >= HALT_CYC && tail_same()) begin
                    m_halt = 1;
                    m_mode = M_DONE;
                end else if (m_run.size() == MAX_CYC) begin
                    m_tout = 1;
                    m_mode = M_DONE;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    always @(negedge clk) begin
        if (reset) begin
            model_clear();
            m_mode = M_IDLE;
        end
        chk("cpu_reset", cpu_reset, m_mode != M_RUN);
        chk("s_ready", s_ready, m_mode == M_LOAD);
        chk("busy", busy, m_mode == M_LOAD || m_mode == M_HOLD || m_mode == M_RUN);
        chk("done", done, m_mode == M_DONE);
        chk("halted", halted, m_halt);
        chk("timeout", timeout, m_tout);
        chk("overflow", overflow, m_ovf);
        chk("words_loaded", words_loaded, m_img.size());
        chk("cycles", cycles, m_run.size());
        chk("rom_we", rom_we, m_mode == M_LOAD && s_valid);
`ifdef HACK_LOADER_CHECKSUM_EN
        chk("checksum", checksum, m_chk);
`endif
        if (m_mode == M_LOAD && s_valid) begin
            chk("rom_addr", rom_addr, m_img.size());
            chk("rom_wdata", rom_wdata, s_data);
        end
        if (rom_we) begin
            writes_seen++;
            rom_log[rom_addr] = rom_wdata;
        end
        if (!reset) model_step();
        m_now++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit pc_inc);
        int n = 0;
        while (!done && n < limit) begin
            if (pc_inc) pc_in = pc_in + 1'b1;
            tick();
            n++;
        end
        chk("done_within_bound", done, 1);
    endtask

    initial begin
        int n;
        int w0;
        int pc_left;

        tick();
        tick();
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_words_loaded", words_loaded, 0);
        chk("rst_rom_addr", rom_addr, 0);
        reset = 1'b0;
        tick();

        // Three-word program, then a halt with PC parked at 5.
        pc_in = 16'd5;
        pulse_start();
        w0 = writes_seen;
        send(16'h0002, 0);
        send(16'hEC10, 0);
        send(16'h0000, 1);
        chk("load3_writes", writes_seen - w0, 3);
        chk("load3_rom0", rom_log[0], 16'h0002);
        chk("load3_rom1", rom_log[1], 16'hEC10);
        chk("load3_rom2", rom_log[2], 16'h0000);
        chk("load3_words", words_loaded, 3);
        n = 0;
        while (cpu_reset && n < 20) begin
            tick();
            n++;
        end
        chk("hold_cycles", n, RST_HOLD);
        wait_done(100, 0);
        chk("halt_flag", halted, 1);
        chk("halt_timeout", timeout, 0);
        chk("halt_cycles", cycles, 8);

        // Ever-changing PC runs into the cycle limit.
        pulse_start();
        send(16'h1234, 1);
        pc_in = '0;
        wait_done(1100, 1);
        chk("tout_flag", timeout, 1);
        chk("tout_halted", halted, 0);
        chk("tout_cycles", cycles, 1000);

        // Fill all four locations without s_last; a fifth word must not be written.
        pulse_start();
        w0 = writes_seen;
        s_valid = 1'b1;
        s_last  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            s_data = 16'(i * 3 + 1);
            tick();
        end
        chk("ovf_s_ready", s_ready, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_words", words_loaded, 4);
        s_data = 16'hBEEF;
        tick();
        s_valid = 1'b0;
        chk("ovf_writes", writes_seen - w0, 4);
        pc_in = 16'd9;
        wait_done(200, 0);

        // Reset in the middle of a load, then stray stream traffic.
        pulse_start();
        send(16'h0101, 0);
        send(16'h0202, 0);
        reset = 1'b1;
        #1;
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_words", words_loaded, 0);
        chk("midrst_busy", busy, 0);
        tick();
        reset = 1'b0;
        w0 = writes_seen;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 16'($urandom);
            tick();
        end
        s_valid = 1'b0;
        chk("midrst_no_writes", writes_seen - w0, 0);
        chk("midrst_s_ready", s_ready, 0);

`ifdef HACK_LOADER_CHECKSUM_EN
        pulse_start();
        send(16'hFFFF, 0);
        send(16'h0002, 1);
        chk("cksum_sum", checksum, 16'h0001);
        pc_in = 16'd3;
        wait_done(100, 0);
        pulse_start();
        chk("cksum_clear", checksum, 16'h0000);
        tick();
`endif

        // Randomized traffic: stray starts, gaps, optional s_last, chunked PC, rare resets.
        pc_left = 0;
        for (int c = 0; c < 25000; c++) begin
            start   = ($urandom_range(0, 39) == 0);
            s_valid = $urandom_range(0, 1) != 0;
            s_data  = 16'($urandom);
            s_last  = ($urandom_range(0, 2) == 0);
            reset   = ($urandom_range(0, 2999) == 0);
            if (pc_left == 0) begin
                pc_in   = 16'($urandom_range(0, 7));
                pc_left = $urandom_range(1, 10);
            end
            pc_left--;
            tick();
        end
        reset   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
